ps2_key_tracker: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver. Consumes one Set-2 scancode byte per valid strobe.
- Tracks make/break sequences (F0 break prefix, E0 extended prefix).
- Maintains held-state flags for the four game keys: W, S, P, L.
- Produces per-paddle direction outputs for the pong game logic, plus a one-cycle key-event strobe.

---
 rtl/ps2_key_tracker.sv | 157 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Decodes PS/2 Set-2 make/break byte streams into held-key flags
//                for W/S/P/L and per-paddle direction outputs.
//                Optional feature macro: PS2_ARROW_KEYS_EN (E0 75 / E0 72
//                act as P / L).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       clear,
    output logic       key_w,
    output logic       key_s,
    output logic       key_p,
    output logic       key_l,
    output logic       left_up,
    output logic       left_down,
    output logic       right_up,
    output logic       right_down,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_released
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_P     = 8'h4D;
    localparam logic [7:0] CODE_L     = 8'h4B;
`ifdef PS2_ARROW_KEYS_EN
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam int         NFLAG      = 6;
`else
    localparam int         NFLAG      = 4;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    // Flag order: W, S, P, L, then arrow-up, arrow-down when enabled.
    logic [NFLAG-1:0]  flags_q;
    logic [NFLAG-1:0]  flags_d;
    logic [NFLAG-1:0]  sel_d;
    logic              key_event_q;
    logic [7:0]        key_code_q;
    logic              key_released_q;

    logic              is_prefix_d;
    logic              release_d;
    logic              changed_d;

    assign is_prefix_d = (code_in == CODE_BREAK) || (code_in == CODE_EXT);
    assign release_d   = (state_q == S_BREAK) || (state_q == S_EXT_BREAK);

    always_comb begin
        sel_d = '0;
        if (!is_prefix_d) begin
            if ((state_q == S_IDLE) || (state_q == S_BREAK)) begin
                sel_d[3:0] = {code_in == CODE_L, code_in == CODE_P,
                              code_in == CODE_S, code_in == CODE_W};
            end
`ifdef PS2_ARROW_KEYS_EN
            else begin
                sel_d[5:4] = {code_in == CODE_DOWN, code_in == CODE_UP};
            end
`endif
        end
        flags_d = release_d ? (flags_q & ~sel_d) : (flags_q | sel_d);
    end

    // Repeats and releases of unheld keys leave flags_d equal to flags_q.
    assign changed_d = (flags_d != flags_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            flags_q        <= '0;
            key_event_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_released_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                flags_q <= '0;
            end else if (code_valid) begin
                cnt_q <= '0;
                if (code_in == CODE_BREAK) begin
                    state_q <= ((state_q == S_IDLE) || (state_q == S_BREAK))
                               ? S_BREAK : S_EXT_BREAK;
                end else if (code_in == CODE_EXT) begin
                    state_q <= ((state_q == S_IDLE) || (state_q == S_EXT))
                               ? S_EXT : S_EXT_BREAK;
                end else begin
                    state_q <= S_IDLE;
                    flags_q <= flags_d;
                    if (changed_d) begin
                        key_event_q    <= 1'b1;
                        key_code_q     <= code_in;
                        key_released_q <= release_d;
                    end
                end
            end else if (state_q != S_IDLE) begin
                // A stale prefix is abandoned without touching the flags.
                if (cnt_q == CNT_LAST) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign key_w = flags_q[0];
    assign key_s = flags_q[1];
`ifdef PS2_ARROW_KEYS_EN
    assign key_p = flags_q[2] | flags_q[4];
    assign key_l = flags_q[3] | flags_q[5];
`else
    assign key_p = flags_q[2];
    assign key_l = flags_q[3];
`endif

    assign left_up      = key_w & ~key_s;
    assign left_down    = key_s & ~key_w;
    assign right_up     = key_p & ~key_l;
    assign right_down   = key_l & ~key_p;

    assign key_event    = key_event_q;
    assign key_code     = key_code_q;
    assign key_released = key_released_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_tracker
//  Description : Self-checking bench for ps2_key_tracker against a byte-stream
//                reference model (honours PS2_ARROW_KEYS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam logic [15:0] C_T = 16'd24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       clear = 1'b0;
    logic       key_w, key_s, key_p, key_l;
    logic       left_up, left_down, right_up, right_down;
    logic       key_event, key_released;
    logic [7:0] key_code;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES(C_T),
        .CNT_W         (16)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .clear       (clear),
        .key_w       (key_w),
        .key_s       (key_s),
        .key_p       (key_p),
        .key_l       (key_l),
        .left_up     (left_up),
        .left_down   (left_down),
        .right_up    (right_up),
        .right_down  (right_down),
        .key_event   (key_event),
        .key_code    (key_code),
        .key_released(key_released)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int evt_seen = 0;

    // Reference state: held sources W,S,P,L,UP,DOWN plus pending prefix bits.
    bit         held[6];
    bit         pend_brk;
    bit         pend_ext;
    logic [7:0] m_code;
    bit         m_rel;
    bit         m_evt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_vec();
        return {14'd0, key_code, key_w, key_s, key_p, key_l,
                left_up, left_down, right_up, right_down, key_event, key_released};
    endfunction

    function automatic logic [31:0] exp_vec();
        bit kw, ks, kp, kl;
        kw = held[0];
        ks = held[1];
        kp = held[2] | held[4];
        kl = held[3] | held[5];
        return {14'd0, m_code, kw, ks, kp, kl,
                kw & ~ks, ks & ~kw, kp & ~kl, kl & ~kp, m_evt, m_rel};
    endfunction

    function automatic int lookup(input logic [7:0] b, input bit ext);
        if (!ext) begin
            case (b)
                8'h1D:   return 0;
                8'h1B:   return 1;
                8'h4D:   return 2;
                8'h4B:   return 3;
                default: return -1;
            endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        if (b == 8'h75) return 4;
        if (b == 8'h72) return 5;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) held[i] = 1'b0;
        pend_brk = 1'b0;
        pend_ext = 1'b0;
        m_code   = 8'h00;
        m_rel    = 1'b0;
        m_evt    = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        m_evt = 1'b0;
        if (b == 8'hF0) begin
            pend_brk = 1'b1;
        end else if (b == 8'hE0) begin
            pend_ext = 1'b1;
        end else begin
            idx = lookup(b, pend_ext);
            if (idx >= 0 && held[idx] != !pend_brk) begin
                held[idx] = !pend_brk;
                m_evt     = 1'b1;
                m_code    = b;
                m_rel     = pend_brk;
            end
            pend_brk = 1'b0;
            pend_ext = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        code_in    = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code_in    = 8'($urandom);
        model_byte(b);
        if (key_event) evt_seen++;
        check(tag, got_vec(), exp_vec());
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) @(negedge clk);
        m_evt = 1'b0;
        if (n >= int'(C_T)) begin
            pend_brk = 1'b0;
            pend_ext = 1'b0;
        end
        check(tag, got_vec(), exp_vec());
    endtask

    task automatic do_clear(input bit with_byte, input logic [7:0] b, input string tag);
        clear      = 1'b1;
        code_valid = with_byte;
        code_in    = b;
        @(negedge clk);
        clear      = 1'b0;
        code_valid = 1'b0;
        for (int i = 0; i < 6; i++) held[i] = 1'b0;
        pend_brk = 1'b0;
        pend_ext = 1'b0;
        m_evt    = 1'b0;
        check(tag, got_vec(), exp_vec());
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 16))
            0, 1:    return 8'h1D;
            2, 3:    return 8'h1B;
            4, 5:    return 8'h4D;
            6, 7:    return 8'h4B;
            8, 9:    return 8'hF0;
            10:      return 8'hE0;
            11:      return 8'h75;
            12:      return 8'h72;
            13:      return 8'hFA;
            14:      return 8'hAA;
            15:      return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        int base;
        int g;
        int r;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset", got_vec(), exp_vec());
        rst_n = 1'b1;
        @(negedge clk);

        send(8'h1D, "make_w");
        check("make_w_evt", {31'd0, key_event}, 32'd1);
        check("make_w_up", {31'd0, left_up}, 32'd1);

        base = evt_seen - 1;
        send(8'hF0, "brk_pfx");
        send(8'h1D, "brk_w");
        check("w_released", {31'd0, key_w}, 32'd0);
        check("evt_pulses", 32'(evt_seen - base), 32'd2);

        send(8'h1D, "ws_w");
        send(8'h1B, "ws_s");
        check("ws_stop", {30'd0, left_up, left_down}, 32'd0);
        send(8'hF0, "ws_pfx");
        send(8'h1D, "ws_rel_w");
        check("ws_down", {31'd0, left_down}, 32'd1);
        send(8'hF0, "s_pfx");
        send(8'h1B, "s_rel");

        send(8'h1D, "typ_make");
        send(8'h1D, "typ_repeat");
        check("typ_no_evt", {31'd0, key_event}, 32'd0);
        send(8'hF0, "to_short_pfx");
        idle(int'(C_T) - 2, "to_short_gap");
        send(8'h1D, "to_short_brk");
        check("to_short_rel", {31'd0, key_w}, 32'd0);
        send(8'hF0, "dup_pfx");
        send(8'h1D, "dup_brk");
        check("dup_no_evt", {31'd0, key_event}, 32'd0);

        send(8'hF0, "to_pfx");
        idle(int'(C_T), "to_gap");
        send(8'h1D, "to_make");
        check("to_make_w", {30'd0, key_w, key_released}, 32'd2);
        send(8'hF0, "to_rel_pfx");
        send(8'h1D, "to_rel");

        send(8'h4D, "hold_p");
        do_clear(1'b1, 8'h4B, "clear_wins");
        check("clear_pl", {29'd0, key_p, key_l, key_event}, 32'd0);

        send(8'hE0, "arr_e0");
        send(8'h75, "arr_make");
`ifdef PS2_ARROW_KEYS_EN
        check("arr_up", {30'd0, right_up, key_event}, 32'd3);
`else
        check("arr_up", {30'd0, right_up, key_event}, 32'd0);
`endif
        send(8'hE0, "arr_e0b");
        send(8'hF0, "arr_f0");
        send(8'h75, "arr_break");
        check("arr_up_off", {31'd0, right_up}, 32'd0);

        for (int it = 0; it < 600; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      g = 0;
            else if (r < 9) g = int'($urandom_range(1, 3));
            else            g = int'(C_T) + int'($urandom_range(0, 5));
            if (g > 0) idle(g, "rnd_gap");
            if ($urandom_range(0, 99) < 4)
                do_clear(1'($urandom_range(0, 1)), pick_byte(), "rnd_clear");
            else
                send(pick_byte(), "rnd_byte");
        end

        send(8'h1D, "pre_arst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst", got_vec(), exp_vec());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h4B, "post_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
